nco_phase_gen: RTL



---
 rtl/nco_pkg.sv | 14 +
 rtl/nco_rate_div.sv | 43 ++++
 rtl/nco_phase_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared widths and state encoding for the NCO phase generator.
package nco_pkg;

  localparam int PHASE_BITS_DEF = 47;
  localparam int CNT_BITS_DEF   = 32;
  localparam int DIV_BITS_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nco_state_e;

endpackage

// File: rtl/nco_rate_div.sv
// Loadable down-counter that ticks once every (load_val_i + 1) enabled cycles.
module nco_rate_div #(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [DIV_BITS-1:0] load_val_i,
  output logic                tick_o
);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;

  // Next count: clear wins, reload on tick, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {DIV_BITS{1'b0}};
    end else if (en_i) begin
      if (cnt_q == {DIV_BITS{1'b0}}) begin
        cnt_d = load_val_i;
      end else begin
        cnt_d = cnt_q - {{(DIV_BITS-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= {DIV_BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == {DIV_BITS{1'b0}});

endmodule

// File: rtl/nco_phase_gen.sv
// Programmable NCO / chirp phase source feeding the sine interpolation stage.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int PHASE_BITS = PHASE_BITS_DEF,
  parameter int CNT_BITS   = CNT_BITS_DEF,
  parameter int DIV_BITS   = DIV_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [PHASE_BITS-1:0] ftw_i,
  input  logic [PHASE_BITS-1:0] dftw_i,
  input  logic [PHASE_BITS-1:0] poff_i,
  input  logic [CNT_BITS-1:0]   nsamp_i,
  input  logic [DIV_BITS-1:0]   div_i,
  output logic                  valid_o,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  busy_o,
  output logic                  done_o
);

  nco_state_e state_q, state_d;
  logic [PHASE_BITS-1:0] acc_q, acc_d;
  logic [PHASE_BITS-1:0] ftw_cur_q, ftw_cur_d;
  logic [PHASE_BITS-1:0] dftw_q, dftw_d;
  logic [PHASE_BITS-1:0] poff_q, poff_d;
  logic [CNT_BITS-1:0]   nsamp_q, nsamp_d;
  logic [CNT_BITS-1:0]   smp_cnt_q, smp_cnt_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic                  valid_q, valid_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_clr_s;
  logic                  div_en_s;
  logic                  div_tick_s;

  nco_rate_div #(
    .DIV_BITS (DIV_BITS)
  ) u_rate_div (
    .clk        (clk),
    .resetn     (resetn),
    .clear_i    (div_clr_s),
    .en_i       (div_en_s),
    .load_val_i (div_q),
    .tick_o     (div_tick_s)
  );

  // FSM next state, sample generation and configuration latching.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ftw_cur_d = ftw_cur_q;
    dftw_d    = dftw_q;
    poff_d    = poff_q;
    nsamp_d   = nsamp_q;
    smp_cnt_d = smp_cnt_q;
    div_d     = div_q;
    valid_d   = 1'b0;
    phase_d   = phase_q;
    done_d    = 1'b0;
    div_clr_s = 1'b0;
    div_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          acc_d     = {PHASE_BITS{1'b0}};
          ftw_cur_d = ftw_i;
          dftw_d    = dftw_i;
          poff_d    = poff_i;
          nsamp_d   = nsamp_i;
          smp_cnt_d = {CNT_BITS{1'b0}};
          div_d     = div_i;
          div_clr_s = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          div_en_s = 1'b1;
          if (div_tick_s) begin
            valid_d   = 1'b1;
            phase_d   = acc_q + poff_q;
            acc_d     = acc_q + ftw_cur_q;
            ftw_cur_d = ftw_cur_q + dftw_q;
            smp_cnt_d = smp_cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
            // nsamp of zero means continuous: the counter just wraps.
            if ((nsamp_q != {CNT_BITS{1'b0}}) && (smp_cnt_d == nsamp_q)) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      acc_q     <= {PHASE_BITS{1'b0}};
      ftw_cur_q <= {PHASE_BITS{1'b0}};
      dftw_q    <= {PHASE_BITS{1'b0}};
      poff_q    <= {PHASE_BITS{1'b0}};
      nsamp_q   <= {CNT_BITS{1'b0}};
      smp_cnt_q <= {CNT_BITS{1'b0}};
      div_q     <= {DIV_BITS{1'b0}};
      valid_q   <= 1'b0;
      phase_q   <= {PHASE_BITS{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ftw_cur_q <= ftw_cur_d;
      dftw_q    <= dftw_d;
      poff_q    <= poff_d;
      nsamp_q   <= nsamp_d;
      smp_cnt_q <= smp_cnt_d;
      div_q     <= div_d;
      valid_q   <= valid_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign phase_o = phase_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
